// File: rtl/alu_daa.sv
`default_nettype none
// ============================================================================
// Module   : alu_daa
// Function : Two-stage 6502 ALU: binary adder hold register, then BCD adjust.
// Revision : 1.0
// ============================================================================
module alu_daa (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       START,
    input  logic       STALL,
    input  logic [7:0] A_DATA,
    input  logic [7:0] B_DATA,
    input  logic [2:0] OP,
    input  logic       CIN,
    input  logic       DECIMAL,
    output logic [7:0] ADD_OUT,
    output logic [7:0] DAA_OUT,
    output logic       VALID,
    output logic       COUT,
    output logic       VOUT,
    output logic       NOUT,
    output logic       ZOUT
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_EOR = 3'b100;
    localparam logic [2:0] OP_SR  = 3'b101;

    localparam logic [1:0] CLS_OTHER = 2'd0;
    localparam logic [1:0] CLS_ADD   = 2'd1;
    localparam logic [1:0] CLS_SUB   = 2'd2;

    // Stage-1 state
    logic [7:0] add_q, add_d;
    logic       c1_q, c1_d;
    logic       vf1_q, vf1_d;
    logic       hc1_q, hc1_d;
    logic [1:0] cls1_q, cls1_d;
    logic       dec1_q, dec1_d;
    logic       v1_q, v1_d;

    // Stage-2 state
    logic [7:0] daa_q, daa_d;
    logic       cout_q, cout_d;
    logic       vout_q, vout_d;
    logic       nout_q, nout_d;
    logic       zout_q, zout_d;
    logic       v2_q, v2_d;

    logic [7:0] bx;
    logic [8:0] sum9;
    logic       hc;
    logic       add_gt99;
    logic [7:0] corr_lo;
    logic [7:0] corr_hi;

    // Half carry recovered from the full sum: bit-4 sum = A4 ^ B4 ^ carry-in-to-4
    always_comb begin
        bx   = (OP == OP_SUB) ? ~B_DATA : B_DATA;
        sum9 = {1'b0, A_DATA} + {1'b0, bx} + {8'd0, CIN};
        hc   = sum9[4] ^ A_DATA[4] ^ bx[4];
    end

    always_comb begin
        add_d  = add_q;
        c1_d   = c1_q;
        vf1_d  = vf1_q;
        hc1_d  = hc1_q;
        cls1_d = cls1_q;
        dec1_d = dec1_q;
        v1_d   = v1_q;
        if (!STALL) begin
            v1_d = START;
            if (START) begin
                dec1_d = DECIMAL;
                hc1_d  = 1'b0;
                vf1_d  = 1'b0;
                c1_d   = CIN;
                cls1_d = CLS_OTHER;
                case (OP)
                    OP_ADD, OP_SUB: begin
                        add_d  = sum9[7:0];
                        c1_d   = sum9[8];
                        hc1_d  = hc;
                        vf1_d  = (A_DATA[7] == bx[7]) && (sum9[7] != A_DATA[7]);
                        cls1_d = (OP == OP_SUB) ? CLS_SUB : CLS_ADD;
                    end
                    OP_AND:  add_d = A_DATA & B_DATA;
                    OP_OR:   add_d = A_DATA | B_DATA;
                    OP_EOR:  add_d = A_DATA ^ B_DATA;
                    OP_SR: begin
                        add_d = {CIN, A_DATA[7:1]};
                        c1_d  = A_DATA[0];
                    end
                    default: add_d = A_DATA;
                endcase
            end
        end
    end

    // Decimal correction terms; subtraction subtracts 6/0x60 via FA/A0 mod 256
    always_comb begin
        add_gt99 = (add_q > 8'h99);
        corr_lo  = 8'h00;
        corr_hi  = 8'h00;
        if (dec1_q && (cls1_q == CLS_ADD)) begin
            corr_lo = (hc1_q || (add_q[3:0] > 4'd9)) ? 8'h06 : 8'h00;
            corr_hi = (c1_q || add_gt99) ? 8'h60 : 8'h00;
        end else if (dec1_q && (cls1_q == CLS_SUB)) begin
            corr_lo = hc1_q ? 8'h00 : 8'hFA;
            corr_hi = c1_q  ? 8'h00 : 8'hA0;
        end
    end

    always_comb begin
        daa_d  = daa_q;
        cout_d = cout_q;
        vout_d = vout_q;
        nout_d = nout_q;
        zout_d = zout_q;
        v2_d   = v2_q;
        if (!STALL) begin
            v2_d = v1_q;
            if (v1_q) begin
                daa_d  = add_q + corr_lo + corr_hi;
                cout_d = (dec1_q && (cls1_q == CLS_ADD)) ? (c1_q || add_gt99) : c1_q;
                vout_d = vf1_q;
                nout_d = add_q[7];
                zout_d = (add_q == 8'h00);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            add_q  <= 8'h00;
            c1_q   <= 1'b0;
            vf1_q  <= 1'b0;
            hc1_q  <= 1'b0;
            cls1_q <= CLS_OTHER;
            dec1_q <= 1'b0;
            v1_q   <= 1'b0;
            daa_q  <= 8'h00;
            cout_q <= 1'b0;
            vout_q <= 1'b0;
            nout_q <= 1'b0;
            zout_q <= 1'b0;
            v2_q   <= 1'b0;
        end else begin
            add_q  <= add_d;
            c1_q   <= c1_d;
            vf1_q  <= vf1_d;
            hc1_q  <= hc1_d;
            cls1_q <= cls1_d;
            dec1_q <= dec1_d;
            v1_q   <= v1_d;
            daa_q  <= daa_d;
            cout_q <= cout_d;
            vout_q <= vout_d;
            nout_q <= nout_d;
            zout_q <= zout_d;
            v2_q   <= v2_d;
        end
    end

    assign ADD_OUT = add_q;
    assign DAA_OUT = daa_q;
    assign COUT    = cout_q;
    assign VOUT    = vout_q;
    assign NOUT    = nout_q;
    assign ZOUT    = zout_q;
    assign VALID   = v2_q && !STALL;

endmodule
`default_nettype wire

// File: tb/tb_alu_daa.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_daa
// Function : Scoreboard bench for alu_daa with a decimal-arithmetic model.
// Revision : 1.0
// ============================================================================
module tb_alu_daa;

    typedef struct packed {
        logic [7:0] add;
        logic [7:0] daa;
        logic       c;
        logic       v;
        logic       n;
        logic       z;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       START = 1'b0;
    logic       STALL = 1'b0;
    logic [7:0] A_DATA = 8'h00;
    logic [7:0] B_DATA = 8'h00;
    logic [2:0] OP = 3'b000;
    logic       CIN = 1'b0;
    logic       DECIMAL = 1'b0;
    logic [7:0] ADD_OUT;
    logic [7:0] DAA_OUT;
    logic       VALID;
    logic       COUT;
    logic       VOUT;
    logic       NOUT;
    logic       ZOUT;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sbq[$];
    int   valid_cycles[$];

    alu_daa dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .STALL(STALL),
        .A_DATA(A_DATA), .B_DATA(B_DATA), .OP(OP), .CIN(CIN), .DECIMAL(DECIMAL),
        .ADD_OUT(ADD_OUT), .DAA_OUT(DAA_OUT), .VALID(VALID), .COUT(COUT),
        .VOUT(VOUT), .NOUT(NOUT), .ZOUT(ZOUT)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int bcd2i(input logic [7:0] x);
        return int'(x[7:4]) * 10 + int'(x[3:0]);
    endfunction

    function automatic logic [7:0] i2bcd(input int x);
        logic [3:0] t;
        logic [3:0] o;
        t = 4'(x / 10);
        o = 4'(x % 10);
        return {t, o};
    endfunction

    function automatic int sgn(input logic [7:0] x);
        return x[7] ? int'(x) - 256 : int'(x);
    endfunction

    // Reference: plain integer arithmetic, decimal modes done in base ten
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic [2:0] op, input logic cin, input logic dec);
        exp_t e;
        int   s;
        int   sv;
        int   d;
        int   ci;
        ci = int'(cin);
        e  = '0;
        case (op)
            3'd0: begin
                s     = int'(a) + int'(b) + ci;
                sv    = sgn(a) + sgn(b) + ci;
                e.add = 8'(s);
                e.c   = (s > 255);
                e.v   = (sv > 127) || (sv < -128);
                e.daa = e.add;
                if (dec) begin
                    d     = bcd2i(a) + bcd2i(b) + ci;
                    e.c   = (d > 99);
                    e.daa = i2bcd(d % 100);
                end
            end
            3'd1: begin
                s     = int'(a) - int'(b) - (1 - ci);
                sv    = sgn(a) - sgn(b) - (1 - ci);
                e.add = 8'(s + 256);
                e.c   = (s >= 0);
                e.v   = (sv > 127) || (sv < -128);
                e.daa = e.add;
                if (dec) begin
                    d   = bcd2i(a) - bcd2i(b) - (1 - ci);
                    e.c = (d >= 0);
                    if (d < 0) d = d + 100;
                    e.daa = i2bcd(d);
                end
            end
            3'd2: begin e.add = a & b; e.c = cin; e.daa = e.add; end
            3'd3: begin e.add = a | b; e.c = cin; e.daa = e.add; end
            3'd4: begin e.add = a ^ b; e.c = cin; e.daa = e.add; end
            3'd5: begin e.add = 8'((int'(a) / 2) + ci * 128); e.c = a[0]; e.daa = e.add; end
            default: begin e.add = a; e.c = cin; e.daa = e.add; end
        endcase
        e.n = (e.add >= 8'd128);
        e.z = (e.add == 8'd0);
        return e;
    endfunction

    task automatic issue(input logic st, input logic stl, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op, input logic cin, input logic dec,
                         input logic use_exp, input exp_t ex);
        exp_t e;
        @(negedge CLK);
        START = st; STALL = stl; A_DATA = a; B_DATA = b; OP = op; CIN = cin; DECIMAL = dec;
        e = use_exp ? ex : model(a, b, op, cin, dec);
        if (st && !stl) sbq.push_back(e);
        @(posedge CLK);
        #1;
        if (st && !stl) check("add_out", {24'd0, ADD_OUT}, {24'd0, e.add});
    endtask

    task automatic idle(input logic stl);
        issue(1'b0, stl, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1, '0);
    endtask

    task automatic directed(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                            input logic cin, input logic dec, input exp_t ex);
        issue(1'b1, 1'b0, a, b, op, cin, dec, 1'b1, ex);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 10) begin
            idle(1'b0);
            n++;
        end
        idle(1'b0);
        check("drain", sbq.size(), 0);
    endtask

    // Monitor: compares every presented result against the head of the queue
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            #1;
            if (RST_N && VALID) begin
                valid_cycles.push_back(cyc);
                if (sbq.size() == 0) begin
                    check("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    check("result", {20'd0, DAA_OUT, COUT, VOUT, NOUT, ZOUT},
                          {20'd0, e.daa, e.c, e.v, e.n, e.z});
                end
            end
        end
    end

    initial begin
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic       dec;
        int         nv;

        repeat (3) @(posedge CLK);
        #1;
        check("rst_outs", {16'd0, ADD_OUT, DAA_OUT}, 32'd0);
        check("rst_flags", {26'd0, VALID, COUT, VOUT, NOUT, ZOUT, 1'b0}, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        // Directed vectors: {add, daa, c, v, n, z}
        directed(8'h50, 8'h50, 3'd0, 1'b0, 1'b0, exp_t'{8'hA0, 8'hA0, 1'b0, 1'b1, 1'b1, 1'b0});
        directed(8'h19, 8'h28, 3'd0, 1'b0, 1'b1, exp_t'{8'h41, 8'h47, 1'b0, 1'b0, 1'b0, 1'b0});
        directed(8'h99, 8'h01, 3'd0, 1'b0, 1'b1, exp_t'{8'h9A, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0});
        directed(8'h42, 8'h13, 3'd1, 1'b1, 1'b1, exp_t'{8'h2F, 8'h29, 1'b1, 1'b0, 1'b0, 1'b0});
        directed(8'h10, 8'h20, 3'd1, 1'b1, 1'b1, exp_t'{8'hF0, 8'h90, 1'b0, 1'b0, 1'b1, 1'b0});
        directed(8'hF0, 8'h3C, 3'd2, 1'b0, 1'b0, exp_t'{8'h30, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0});
        directed(8'hFF, 8'hFF, 3'd4, 1'b0, 1'b0, exp_t'{8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1});
        directed(8'h81, 8'h00, 3'd5, 1'b1, 1'b0, exp_t'{8'hC0, 8'hC0, 1'b1, 1'b0, 1'b1, 1'b0});
        directed(8'h7E, 8'h55, 3'd6, 1'b1, 1'b1, exp_t'{8'h7E, 8'h7E, 1'b1, 1'b0, 1'b0, 1'b0});
        drain();

        // Stall in the middle of three back-to-back operations
        valid_cycles.delete();
        directed(8'h01, 8'h02, 3'd0, 1'b0, 1'b0, exp_t'{8'h03, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0});
        directed(8'h0C, 8'h0A, 3'd3, 1'b0, 1'b0, exp_t'{8'h0E, 8'h0E, 1'b0, 1'b0, 1'b0, 1'b0});
        directed(8'h05, 8'h03, 3'd1, 1'b1, 1'b0, exp_t'{8'h02, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0});
        idle(1'b1);
        idle(1'b1);
        drain();
        check("stall_count", valid_cycles.size(), 3);
        if (valid_cycles.size() == 3) begin
            check("stall_gap1", valid_cycles[1] - valid_cycles[0], 3);
            check("stall_gap2", valid_cycles[2] - valid_cycles[1], 1);
        end

        // Randomized traffic with random gaps and stalls
        for (int i = 0; i < 400; i++) begin
            op  = 3'($urandom_range(0, 7));
            dec = 1'($urandom_range(0, 1));
            if (dec && op < 3'd2) begin
                a = i2bcd(int'($urandom_range(0, 99)));
                b = i2bcd(int'($urandom_range(0, 99)));
            end else begin
                a = 8'($urandom);
                b = 8'($urandom);
            end
            issue(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 5) == 0),
                  a, b, op, 1'($urandom_range(0, 1)), dec, 1'b0, '0);
        end
        drain();

        // Asynchronous reset between the two stages of an operation
        nv = valid_cycles.size();
        @(negedge CLK);
        START = 1'b1; STALL = 1'b0; A_DATA = 8'h37; B_DATA = 8'h45; OP = 3'd0; CIN = 1'b1; DECIMAL = 1'b0;
        @(posedge CLK);
        #2;
        START = 1'b0;
        RST_N = 1'b0;
        #1;
        check("mid_rst_outs", {16'd0, ADD_OUT, DAA_OUT}, 32'd0);
        check("mid_rst_flags", {27'd0, VALID, COUT, VOUT, NOUT, ZOUT}, 32'd0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        repeat (4) idle(1'b0);
        check("post_rst_no_valid", valid_cycles.size(), nv);
        directed(8'h08, 8'h09, 3'd0, 1'b0, 1'b1, exp_t'{8'h11, 8'h17, 1'b0, 1'b0, 1'b0, 1'b0});
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
